// File: rtl/dmux_pkg.sv
// Shared types and constants for the n2t demultiplexer gates.
//   dmux4_sel_t        : 2-bit select for the 4-way demux
//   SEL_A..SEL_D       : select codes routing `in` to a, b, c, d
//   DMUX4_REG_LATENCY  : output latency in cycles when registered outputs are built in
package dmux_pkg;

   typedef logic [1:0] dmux4_sel_t;

   localparam dmux4_sel_t SEL_A = 2'b00;
   localparam dmux4_sel_t SEL_B = 2'b01;
   localparam dmux4_sel_t SEL_C = 2'b10;
   localparam dmux4_sel_t SEL_D = 2'b11;

   localparam int DMUX4_REG_LATENCY = 1;

endpackage

// File: rtl/dmux_2_way.sv
// Single-bit 2-way demultiplexer.
// Ports:
//   a   : output, equals in when sel == 0, else 0
//   b   : output, equals in when sel == 1, else 0
//   in  : input, data bit to route
//   sel : input, output select
// Plain AND gating so X/Z on in or sel propagates to the outputs.
module dmux_2_way (
   output logic a,
   output logic b,
   input  logic in,
   input  logic sel
);

   assign a = in & ~sel;
   assign b = in & sel;

endmodule

// File: rtl/dmux_4_way.sv
// Single-bit 4-way demultiplexer built from three 2-way demuxes.
// Ports:
//   clk   : input, clock (only used with registered outputs)
//   rst_n : input, asynchronous active-low reset (only used with registered outputs)
//   a..d  : outputs, `in` routed to the output chosen by sel (00->a .. 11->d), others 0
//   in    : input, data bit to route
//   sel   : input, 2-bit select; sel[1] picks {a,b} or {c,d}, sel[0] picks within the pair
// Configuration macro DMUX_4_WAY_REG_OUT_EN:
//   defined   -> outputs registered on rising clk, 1-cycle latency, async clear to 0
//   undefined -> purely combinational; clk and rst_n are unused
module dmux_4_way
   import dmux_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   output logic       a,
   output logic       b,
   output logic       c,
   output logic       d,
   input  logic       in,
   input  dmux4_sel_t sel
);

   logic lo;
   logic hi;
   logic a_dec;
   logic b_dec;
   logic c_dec;
   logic d_dec;

   // Level 1: sel[1] splits the input into the {a,b} and {c,d} pairs.
   dmux_2_way u_lvl1 (
      .a   (lo),
      .b   (hi),
      .in  (in),
      .sel (sel[1])
   );

   // Level 2: sel[0] picks within each pair.
   dmux_2_way u_lvl2_lo (
      .a   (a_dec),
      .b   (b_dec),
      .in  (lo),
      .sel (sel[0])
   );

   dmux_2_way u_lvl2_hi (
      .a   (c_dec),
      .b   (d_dec),
      .in  (hi),
      .sel (sel[0])
   );

`ifdef DMUX_4_WAY_REG_OUT_EN

   // All four flops share one edge, so a select change never shows two ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a <= 1'b0;
         b <= 1'b0;
         c <= 1'b0;
         d <= 1'b0;
      end else begin
         a <= a_dec;
         b <= b_dec;
         c <= c_dec;
         d <= d_dec;
      end
   end

   a_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0({d, c, b, a}));

   // Outputs lag the inputs by one edge, so compare against the previous sample of in.
   a_zero_when_idle : assert property (@(posedge clk) disable iff (!rst_n)
      ($past(in) == 1'b0) |-> ({d, c, b, a} == 4'b0000));

`else

   assign a = a_dec;
   assign b = b_dec;
   assign c = c_dec;
   assign d = d_dec;

   logic unused_clk_rst;
   assign unused_clk_rst = clk ^ rst_n;

   // Skip while inputs are unknown so X can still reach the outputs unreported.
   always_comb begin
      if (!$isunknown({in, sel})) begin
         a_onehot0 : assert ($onehot0({d, c, b, a}));
         a_zero_when_idle : assert (in || ({d, c, b, a} == 4'b0000));
      end
   end

`endif

endmodule

// File: tb/tb_dmux_4_way.sv
// Self-checking bench for dmux_4_way with directed vectors and hand-computed results.
// Works for both builds; the DMUX_4_WAY_REG_OUT_EN build adds reset and latency checks.
module tb_dmux_4_way;
   import dmux_pkg::*;

   logic       clk;
   logic       rst_n;
   logic       a;
   logic       b;
   logic       c;
   logic       d;
   logic       in;
   dmux4_sel_t sel;

   int unsigned n_checks;
   int unsigned n_errors;

   dmux_4_way u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (a),
      .b     (b),
      .c     (c),
      .d     (d),
      .in    (in),
      .sel   (sel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got dcba=%b expected dcba=%b", tag, got, exp);
      end
   endtask

   // Wait until the outputs reflect the current inputs.
   task automatic settle();
`ifdef DMUX_4_WAY_REG_OUT_EN
      repeat (DMUX4_REG_LATENCY) @(posedge clk);
      #1;
`else
      #10;
`endif
   endtask

   task automatic drive_check(input string tag, input logic i, input dmux4_sel_t s,
                              input logic [3:0] exp);
      in  = i;
      sel = s;
      settle();
      check(tag, {d, c, b, a}, exp);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "simulation timeout");
   end

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n    = 1'b0;
      in       = 1'b0;
      sel      = SEL_A;
      #3;
      check("reset", {d, c, b, a}, 4'b0000);
      @(negedge clk);
      rst_n = 1'b1;

      // in = 0: every select code keeps all outputs low.
      drive_check("in0_sel00", 1'b0, SEL_A, 4'b0000);
      drive_check("in0_sel01", 1'b0, SEL_B, 4'b0000);
      drive_check("in0_sel10", 1'b0, SEL_C, 4'b0000);
      drive_check("in0_sel11", 1'b0, SEL_D, 4'b0000);

      // in = 1: each code selects exactly one output.
      drive_check("in1_sel00", 1'b1, SEL_A, 4'b0001);
      drive_check("in1_sel01", 1'b1, SEL_B, 4'b0010);
      drive_check("in1_sel10", 1'b1, SEL_C, 4'b0100);
      drive_check("in1_sel11", 1'b1, SEL_D, 4'b1000);

      // in held high, walk 00 -> 11 -> 01 -> 10.
      drive_check("walk_a", 1'b1, SEL_A, 4'b0001);
      drive_check("walk_d", 1'b1, SEL_D, 4'b1000);
      drive_check("walk_b", 1'b1, SEL_B, 4'b0010);
      drive_check("walk_c", 1'b1, SEL_C, 4'b0100);

      // Back to zero after a one was routed.
      drive_check("in1_to_0", 1'b0, SEL_C, 4'b0000);

`ifdef DMUX_4_WAY_REG_OUT_EN
      // Async reset between edges clears d immediately and holds it clear.
      drive_check("pre_rst_d", 1'b1, SEL_D, 4'b1000);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("rst_async_clear", {d, c, b, a}, 4'b0000);
      @(posedge clk);
      #1;
      check("rst_hold", {d, c, b, a}, 4'b0000);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_release_no_edge", {d, c, b, a}, 4'b0000);
      @(posedge clk);
      #1;
      check("rst_first_edge", {d, c, b, a}, 4'b1000);

      // Select change right after edge N: a holds until edge N+1, then b.
      drive_check("lat_a", 1'b1, SEL_A, 4'b0001);
      sel = SEL_B;
      #1;
      check("lat_hold_a", {d, c, b, a}, 4'b0001);
      @(posedge clk);
      #1;
      check("lat_b", {d, c, b, a}, 4'b0010);
`else
      // Combinational build: clk and rst_n do not affect the outputs.
      in  = 1'b1;
      sel = SEL_D;
      #10;
      rst_n = 1'b0;
      #10;
      check("rst_ignored", {d, c, b, a}, 4'b1000);
      rst_n = 1'b1;
      sel   = SEL_B;
      #10;
      check("after_rst_b", {d, c, b, a}, 4'b0010);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/dmux_4_way.md
# dmux_4_way

Single-bit, four-way demultiplexer in the n2t gate library, built on the 2-way demux and used as the next building block up. It routes input `in` to exactly one of four outputs `a`, `b`, `c`, `d`, chosen by the 2-bit `sel`. The three unselected outputs are always 0. A compile-time option registers the outputs behind the block's clock and asynchronous active-low reset.

## Interface
Parameters: none.

Ports, in this positional order after the clock and reset (`a, b, c, d, in, sel`):
- `clk`  input  1  clock; one clock for the block; only used when registered outputs are compiled in
- `rst_n`  input  1  reset; asynchronous, active-low
- `a`  output  1  equals `in` when `sel == 2'b00`, else 0
- `b`  output  1  equals `in` when `sel == 2'b01`, else 0
- `c`  output  1  equals `in` when `sel == 2'b10`, else 0
- `d`  output  1  equals `in` when `sel == 2'b11`, else 0
- `in`  input  1  data bit to route
- `sel`  input  2  output select; `sel[1]` picks the pair {a,b} or {c,d}, `sel[0]` picks within the pair

## Operation
- Decode: `a = in & ~sel[1] & ~sel[0]`, `b = in & ~sel[1] & sel[0]`, `c = in & sel[1] & ~sel[0]`, `d = in & sel[1] & sel[0]`.
- At most one output is 1 at any time.
- All four outputs are 0 whenever `in == 0`, for every `sel`.
- Build it as two decode levels:
  - Level 1: `dmux_2_way` on `sel[1]` gives intermediate `lo` (feeds a/b) and `hi` (feeds c/d).
  - Level 2: two `dmux_2_way` instances on `sel[0]` split `lo` into a/b and `hi` into c/d.
- X/Z on `sel` or `in` must not be masked. Outputs go X rather than taking a default value.

## Timing
- Default build: purely combinational, zero cycles of latency.
  - Outputs settle within one gate-delay budget of any change on `in` or `sel`.
  - `clk` and `rst_n` have no effect on the outputs.
- `DMUX_4_WAY_REG_OUT_EN` build:
  - `a..d` come from flops loaded on the rising edge of `clk`.
  - Latency is exactly 1 cycle: outputs show the decode of the `in`/`sel` values sampled at the previous edge.
  - `rst_n` low forces `a = b = c = d = 0` immediately, without waiting for a clock edge, and holds them there while low.
  - After `rst_n` deasserts, the first rising edge loads the decoded values.
  - Reset asserted mid-operation clears all outputs at once.
  - An input change and a clock edge in the same timestep: the value present at the edge is captured.
- Both builds: a `sel` change with `in == 1` moves the 1 to the new output. In the registered build the old and new outputs are never both 1, because all four flops update on the same edge.

## Configuration
- Macro `DMUX_4_WAY_REG_OUT_EN`.
  - Defined: registered outputs as described under Timing, with 1-cycle latency and asynchronous active-low clear to 0.
  - Undefined: combinational outputs. `clk` and `rst_n` stay on the port list but are functionally unused; synthesis may warn about them.

## Structure
- Shared package `dmux_pkg`:
  - `typedef logic [1:0] dmux4_sel_t`
  - Select constants `SEL_A = 2'b00`, `SEL_B = 2'b01`, `SEL_C = 2'b10`, `SEL_D = 2'b11`
  - `localparam int DMUX4_REG_LATENCY = 1`
- Sub-module `dmux_2_way` (ports `a, b, in, sel`): `a = in & ~sel`, `b = in & sel`. It is instantiated three times.
- Output register stage and its reset are enclosed in the configuration `ifdef`.
- Assertions sit in the same `ifdef`-guarded region:
  - `$onehot0({d,c,b,a})`
  - `{d,c,b,a} == 0` when `in == 0`

## Test plan
In the combinational build, check 10 time units after each stimulus; in the registered build, check one clock later.
- `in=0`, `sel` swept 00, 01, 10, 11 -> `a=b=c=d=0` for every code.
- `in=1`, `sel=00` -> `a=1, b=0, c=0, d=0`; `sel=01` -> `b=1`, others 0.
- `in=1`, `sel=10` -> `c=1`, others 0; `sel=11` -> `d=1`, others 0.
- `in=1` held, `sel` stepped 00→11→01→10 -> the single 1 follows the select: a, d, b, c. The one-hot assertion never fires.
- Registered build, `in=1`, `sel=11`, `rst_n` pulsed low between clock edges -> `d` drops to 0 immediately. After release, `d` returns to 1 on the first rising edge.
- Registered build, `sel` changed 00→01 at edge N -> `a=1` until edge N+1, then `b=1` and `a=0` on the same edge.
